// File: rtl/clause_loader.sv
// clause_loader: packs a literal stream into fixed 5-slot clauses and writes
// each clause to a clause database row. It flags malformed input and stops.
//
// Ports
//   clock, reset         rising-edge clock and synchronous active-high reset
//   lit_valid/lit_ready  handshake for one literal (lit_var, lit_neg, lit_last)
//   load_done            pulse that marks the end of the formula stream
//   db_we, db_addr       one-cycle write strobe and the row being written
//   mask_out, pole_out   per-slot present bits and polarity bits
//   var1_out..var5_out   variable index for each slot
//   clause_count         number of clauses written so far
//   loaded, error        sticky status bits; err_code gives the failure cause
module clause_loader #(
    parameter int unsigned DB_SIZE  = 512,
    parameter int unsigned MAX_LITS = 5,
    parameter int unsigned VAR_W    = 9
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        lit_valid,
    output logic                        lit_ready,
    input  logic [VAR_W-1:0]            lit_var,
    input  logic                        lit_neg,
    input  logic                        lit_last,
    input  logic                        load_done,
    output logic                        db_we,
    output logic [$clog2(DB_SIZE)-1:0]  db_addr,
    output logic [4:0]                  mask_out,
    output logic [4:0]                  pole_out,
    output logic [VAR_W-1:0]            var1_out,
    output logic [VAR_W-1:0]            var2_out,
    output logic [VAR_W-1:0]            var3_out,
    output logic [VAR_W-1:0]            var4_out,
    output logic [VAR_W-1:0]            var5_out,
    output logic [$clog2(DB_SIZE):0]    clause_count,
    output logic                        loaded,
    output logic                        error,
    output logic [1:0]                  err_code
);

    localparam int unsigned AW     = $clog2(DB_SIZE);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned NSLOT  = 5;

    localparam logic [1:0] ERR_TOO_MANY = 2'd1;
    localparam logic [1:0] ERR_DB_FULL  = 2'd2;
    localparam logic [1:0] ERR_VAR_ZERO = 2'd3;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [4:0]         mask_q, mask_d;
    logic [4:0]         pole_q, pole_d;
    logic [VAR_W-1:0]   var_q [NSLOT];
    logic [VAR_W-1:0]   var_d [NSLOT];
    logic [CW-1:0]      count_q, count_d;
    logic               loaded_q, loaded_d;
    logic               error_q, error_d;
    logic [1:0]         errc_q, errc_d;
    logic               xfer;

    // Handshake and write strobe are gated by reset so a clause in flight
    // never reaches the database once reset is raised.
    assign lit_ready = (state_q == ACCUM) && !reset;
    assign db_we     = (state_q == WRITE) && !reset;
    assign xfer      = lit_valid && lit_ready;

    assign db_addr      = count_q[AW-1:0];
    assign clause_count = count_q;
    assign mask_out     = mask_q;
    assign pole_out     = pole_q;
    assign var1_out     = var_q[0];
    assign var2_out     = var_q[1];
    assign var3_out     = var_q[2];
    assign var4_out     = var_q[3];
    assign var5_out     = var_q[4];
    assign loaded       = loaded_q;
    assign error        = error_q;
    assign err_code     = errc_q;

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        mask_d   = mask_q;
        pole_d   = pole_q;
        var_d    = var_q;
        count_d  = count_q;
        loaded_d = loaded_q;
        error_d  = error_q;
        errc_d   = errc_q;

        case (state_q)
            ACCUM: begin
                if (xfer) begin
                    // Error priority: zero variable, then full database, then overflow
                    if (lit_var == '0) begin
                        state_d = ERR;
                        error_d = 1'b1;
                        errc_d  = ERR_VAR_ZERO;
                    end else if (slot_q == '0 && count_q == CW'(DB_SIZE)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                        errc_d  = ERR_DB_FULL;
                    end else if (slot_q == SLOT_W'(MAX_LITS)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                        errc_d  = ERR_TOO_MANY;
                    end else begin
                        for (int k = 0; k < NSLOT; k++) begin
                            if (slot_q == SLOT_W'(k)) begin
                                var_d[k]  = lit_var;
                                mask_d[k] = 1'b1;
                                pole_d[k] = lit_neg;
                            end
                        end
                        slot_d = slot_q + SLOT_W'(1);
                        if (lit_last) begin
                            state_d = WRITE;
                        end
                    end
                end else if (load_done && slot_q == '0) begin
                    // End of stream is honoured only on a clause boundary
                    state_d  = DONE;
                    loaded_d = 1'b1;
                end
            end
            WRITE: begin
                count_d = count_q + CW'(1);
                slot_d  = '0;
                mask_d  = '0;
                pole_d  = '0;
                for (int k = 0; k < NSLOT; k++) begin
                    var_d[k] = '0;
                end
                state_d = ACCUM;
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ACCUM;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ACCUM;
            slot_q   <= '0;
            mask_q   <= '0;
            pole_q   <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                var_q[k] <= '0;
            end
            count_q  <= '0;
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            mask_q   <= mask_d;
            pole_q   <= pole_d;
            for (int k = 0; k < NSLOT; k++) begin
                var_q[k] <= var_d[k];
            end
            count_q  <= count_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
            errc_q   <= errc_d;
        end
    end

endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader with a 4-row database so the full
// condition is reachable in a few cycles.
module tb_clause_loader;

    localparam int unsigned DB_SIZE = 4;
    localparam int unsigned VAR_W   = 9;

    logic             clock;
    logic             reset;
    logic             lit_valid;
    logic             lit_ready;
    logic [VAR_W-1:0] lit_var;
    logic             lit_neg;
    logic             lit_last;
    logic             load_done;
    logic             db_we;
    logic [1:0]       db_addr;
    logic [4:0]       mask_out;
    logic [4:0]       pole_out;
    logic [VAR_W-1:0] var1_out, var2_out, var3_out, var4_out, var5_out;
    logic [2:0]       clause_count;
    logic             loaded;
    logic             error;
    logic [1:0]       err_code;

    int checks = 0;
    int errors = 0;

    clause_loader #(
        .DB_SIZE (DB_SIZE),
        .MAX_LITS(5),
        .VAR_W   (VAR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lit_valid   (lit_valid),
        .lit_ready   (lit_ready),
        .lit_var     (lit_var),
        .lit_neg     (lit_neg),
        .lit_last    (lit_last),
        .load_done   (load_done),
        .db_we       (db_we),
        .db_addr     (db_addr),
        .mask_out    (mask_out),
        .pole_out    (pole_out),
        .var1_out    (var1_out),
        .var2_out    (var2_out),
        .var3_out    (var3_out),
        .var4_out    (var4_out),
        .var5_out    (var5_out),
        .clause_count(clause_count),
        .loaded      (loaded),
        .error       (error),
        .err_code    (err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        lit_valid = 1'b0;
        load_done = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Offer one literal and hold it until accepted, with a bounded wait
    task automatic send(input logic [VAR_W-1:0] v, input logic n, input logic l);
        logic ok;
        ok        = 1'b0;
        lit_var   = v;
        lit_neg   = n;
        lit_last  = l;
        lit_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ok = lit_ready;
            step();
            if (ok) break;
        end
        lit_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    initial begin
        reset = 1'b1; lit_valid = 1'b0; lit_var = '0; lit_neg = 1'b0;
        lit_last = 1'b0; load_done = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ready", 32'(lit_ready), 32'd0);
        chk("rst_we", 32'(db_we), 32'd0);
        chk("rst_count", 32'(clause_count), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_mask", 32'(mask_out), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(lit_ready), 32'd1);

        // Clause (x3, ~x7, x12)
        send(9'd3, 1'b0, 1'b0);
        chk("accum_we", 32'(db_we), 32'd0);
        send(9'd7, 1'b1, 1'b0);
        send(9'd12, 1'b0, 1'b1);
        chk("c1_we", 32'(db_we), 32'd1);
        chk("c1_addr", 32'(db_addr), 32'd0);
        chk("c1_mask", 32'(mask_out), 32'b00111);
        chk("c1_pole", 32'(pole_out), 32'b00010);
        chk("c1_v1", 32'(var1_out), 32'd3);
        chk("c1_v2", 32'(var2_out), 32'd7);
        chk("c1_v3", 32'(var3_out), 32'd12);
        chk("c1_v4", 32'(var4_out), 32'd0);
        chk("c1_v5", 32'(var5_out), 32'd0);
        chk("c1_ready", 32'(lit_ready), 32'd0);
        step();
        chk("c1_we_off", 32'(db_we), 32'd0);
        chk("c1_count", 32'(clause_count), 32'd1);
        chk("c1_mask_clr", 32'(mask_out), 32'd0);
        chk("c1_v1_clr", 32'(var1_out), 32'd0);

        // Two back-to-back 5-literal clauses then load_done
        do_reset();
        send(9'd1, 1'b1, 1'b0);
        send(9'd2, 1'b0, 1'b0);
        send(9'd3, 1'b1, 1'b0);
        send(9'd4, 1'b0, 1'b0);
        send(9'd5, 1'b1, 1'b1);
        chk("a_we", 32'(db_we), 32'd1);
        chk("a_addr", 32'(db_addr), 32'd0);
        chk("a_mask", 32'(mask_out), 32'b11111);
        chk("a_pole", 32'(pole_out), 32'b10101);
        chk("a_v5", 32'(var5_out), 32'd5);
        chk("a_ready", 32'(lit_ready), 32'd0);
        send(9'd6, 1'b0, 1'b0);
        send(9'd7, 1'b1, 1'b0);
        send(9'd8, 1'b0, 1'b0);
        send(9'd9, 1'b0, 1'b0);
        send(9'd10, 1'b0, 1'b1);
        chk("b_we", 32'(db_we), 32'd1);
        chk("b_addr", 32'(db_addr), 32'd1);
        chk("b_pole", 32'(pole_out), 32'b00010);
        chk("b_v1", 32'(var1_out), 32'd6);
        chk("b_v5", 32'(var5_out), 32'd10);
        chk("b_ready", 32'(lit_ready), 32'd0);
        step();
        chk("b_count", 32'(clause_count), 32'd2);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("done_loaded", 32'(loaded), 32'd1);
        chk("done_ready", 32'(lit_ready), 32'd0);
        step();
        chk("done_sticky", 32'(loaded), 32'd1);
        chk("done_count", 32'(clause_count), 32'd2);
        chk("done_error", 32'(error), 32'd0);

        // Sixth literal in one clause
        do_reset();
        for (int i = 1; i <= 5; i++) send(VAR_W'(i), 1'b0, 1'b0);
        chk("five_we", 32'(db_we), 32'd0);
        chk("five_error", 32'(error), 32'd0);
        send(9'd6, 1'b0, 1'b0);
        chk("six_we", 32'(db_we), 32'd0);
        chk("six_error", 32'(error), 32'd1);
        chk("six_code", 32'(err_code), 32'd1);
        step();
        step();
        chk("six_ready", 32'(lit_ready), 32'd0);
        chk("six_sticky", 32'(error), 32'd1);
        do_reset();
        chk("err_clr", 32'(error), 32'd0);
        chk("code_clr", 32'(err_code), 32'd0);

        // Zero variable outranks overflow
        for (int i = 1; i <= 5; i++) send(VAR_W'(i), 1'b0, 1'b0);
        send(9'd0, 1'b0, 1'b0);
        chk("prio_code", 32'(err_code), 32'd3);

        // Database full
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(VAR_W'(i), 1'b0, 1'b1);
            chk("full_we", 32'(db_we), 32'd1);
            step();
        end
        chk("full_count", 32'(clause_count), 32'd4);
        send(9'd9, 1'b0, 1'b1);
        chk("full_error", 32'(error), 32'd1);
        chk("full_code", 32'(err_code), 32'd2);
        chk("full_count2", 32'(clause_count), 32'd4);
        chk("full_we_off", 32'(db_we), 32'd0);

        // Reset during WRITE suppresses the write
        do_reset();
        send(9'd2, 1'b0, 1'b1);
        chk("wr_we", 32'(db_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("wr_rst_we", 32'(db_we), 32'd0);
        chk("wr_rst_ready", 32'(lit_ready), 32'd0);
        step();
        chk("wr_rst_count", 32'(clause_count), 32'd0);
        reset = 1'b0;
        #1;

        // Reset mid-clause, then a one-literal clause
        send(9'd1, 1'b0, 1'b0);
        send(9'd2, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        chk("mid_mask", 32'(mask_out), 32'd0);
        chk("mid_v1", 32'(var1_out), 32'd0);
        reset = 1'b0;
        #1;
        send(9'd5, 1'b0, 1'b1);
        chk("x5_we", 32'(db_we), 32'd1);
        chk("x5_addr", 32'(db_addr), 32'd0);
        chk("x5_mask", 32'(mask_out), 32'b00001);
        chk("x5_pole", 32'(pole_out), 32'b00000);
        chk("x5_v1", 32'(var1_out), 32'd5);
        chk("x5_v2", 32'(var2_out), 32'd0);
        step();
        chk("x5_count", 32'(clause_count), 32'd1);

        // load_done with one slot pending is ignored
        send(9'd4, 1'b0, 1'b0);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk("ign_loaded", 32'(loaded), 32'd0);
        chk("ign_ready", 32'(lit_ready), 32'd1);

        // Zero variable
        send(9'd0, 1'b1, 1'b0);
        chk("zero_error", 32'(error), 32'd1);
        chk("zero_code", 32'(err_code), 32'd3);
        chk("zero_mask", 32'(mask_out), 32'b00001);
        chk("zero_loaded", 32'(loaded), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clause_loader.md
CLAUSE_LOADER -- requirements
Module: clause_loader

Interface
REQ-001 The block SHALL have parameter DB_SIZE, default 512, giving the clause capacity of the downstream clause database.
REQ-002 The block SHALL have parameter MAX_LITS, default 5, giving the literal slots per clause; it is fixed at 5 in this revision.
REQ-003 The block SHALL have parameter VAR_W, default 9, giving the variable index width.
REQ-004 clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 lit_valid  in  1  a literal is offered on lit_var/lit_neg/lit_last.
REQ-007 lit_ready  out  1  the block accepts the literal this cycle; transfer = lit_valid && lit_ready.
REQ-008 lit_var  in  VAR_W  variable index; 0 is illegal.
REQ-009 lit_neg  in  1  1 = negated literal.
REQ-010 lit_last  in  1  the literal is the final literal of its clause.
REQ-011 load_done  in  1  one-cycle pulse: the formula stream is finished.
REQ-012 db_we  out  1  one-cycle write strobe to the clause database.
REQ-013 db_addr  out  $clog2(DB_SIZE)  database row being written.
REQ-014 mask_out  out  5  slot-present bits; bit k corresponds to slot k+1.
REQ-015 pole_out  out  5  polarity bits; bit k = lit_neg of slot k+1.
REQ-016 var1_out..var5_out  out  VAR_W each  variable index per slot.
REQ-017 clause_count  out  $clog2(DB_SIZE)+1  number of clauses written so far.
REQ-018 loaded  out  1  sticky; the formula has loaded successfully.
REQ-019 error  out  1  sticky; loading has failed.
REQ-020 err_code  out  2  failure cause: 1 = more than 5 literals, 2 = database full, 3 = lit_var==0; 0 when error=0.

Function
REQ-021 The FSM SHALL have exactly four states: ACCUM, WRITE, DONE, ERR.
REQ-022 lit_ready SHALL be 1 only in ACCUM with reset deasserted.
REQ-023 In ACCUM, the k-th accepted literal of a clause (k=0..4) SHALL load var(k+1), set mask bit k, set pole bit k = lit_neg, and increment the slot counter.
REQ-024 Accepting a literal with lit_last=1 SHALL move the FSM to WRITE; db_we SHALL be 1 in the next cycle only, i.e. 1-cycle latency from the last literal to the write.
REQ-025 During the WRITE cycle, db_addr SHALL equal clause_count and mask/pole/var SHALL hold the packed clause; unused slots SHALL be mask 0, pole 0, var 0.
REQ-026 At the end of WRITE, clause_count SHALL increment by 1, the slot counter, mask, pole and vars SHALL clear to 0, and the FSM SHALL return to ACCUM.
REQ-027 db_we SHALL be 0 in every state other than WRITE.
REQ-028 A transfer offered while 5 slots are already filled SHALL NOT be stored; the FSM SHALL enter ERR with err_code 1.
REQ-029 A transfer with lit_var==0 SHALL NOT be stored; the FSM SHALL enter ERR with err_code 3.
REQ-030 A transfer that would start a clause while clause_count==DB_SIZE SHALL NOT be stored; the FSM SHALL enter ERR with err_code 2.
REQ-031 If several error conditions hold on one transfer, the priority SHALL be 3, then 2, then 1.
REQ-032 load_done SHALL take effect only in ACCUM with the slot counter at 0 and no transfer in the same cycle; it SHALL then move the FSM to DONE with loaded=1. Otherwise load_done SHALL be ignored.
REQ-033 DONE and ERR SHALL be terminal until reset; in both states lit_ready=0 and db_we=0.
REQ-034 Duplicate variables within one clause SHALL NOT be checked; they SHALL be stored as given.

Reset
REQ-035 While reset=1, all outputs SHALL be 0 and the FSM SHALL enter ACCUM with all counters cleared. This SHALL hold mid-clause and during WRITE: the partial clause is discarded and no db_we is issued.
REQ-036 lit_ready SHALL first be 1 in the cycle after reset deasserts.

Verification
REQ-037 Clause (x3, ~x7, x12) with lit_last on x12 -> one cycle later: db_we=1, db_addr=0, mask=00111, pole=00010, var1..3=3,7,12, var4/5=0; the next cycle clause_count=1.
REQ-038 Two back-to-back 5-literal clauses, then load_done -> writes at addr 0 and 1, lit_ready=0 during each WRITE, then loaded=1 and clause_count=2.
REQ-039 Sixth literal in one clause -> no db_we, error=1, err_code=1, lit_ready stays 0 until reset.
REQ-040 DB_SIZE=4: 4 single-literal clauses, then a 5th literal -> err_code=2, clause_count=4.
REQ-041 Reset asserted after 2 literals of a clause, then a 1-literal clause (x5) -> write at addr 0 with mask=00001 and var1=5; literal lit_var=0 -> err_code=3; load_done with 1 slot pending -> ignored.
